// File: rtl/count_threshold_monitor_pkg.sv
// rtl/count_threshold_monitor_pkg.sv - shared constants for the count threshold monitor
package count_threshold_monitor_pkg;

    localparam int DEF_WIDTH  = 5;
    localparam int DEF_WRAP_W = 8;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    localparam int CAUSE_THR  = 0;
    localparam int CAUSE_WRAP = 1;

endpackage

// File: rtl/count_threshold_monitor_wrap_detector.sv
// rtl/count_threshold_monitor_wrap_detector.sv - previous-sample tracker and wrap strobe
module count_threshold_monitor_wrap_detector
    import count_threshold_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] COUNT,
    output logic             wrap_strobe,
    output logic             prev_valid
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] prev_count;
    logic             up_wrap;
    logic             down_wrap;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            prev_count <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev_count <= COUNT;
            prev_valid <= 1'b1;
        end
    end

    // A held value never matches both sides, so it can never look like a wrap.
    assign up_wrap     = (prev_count == ALL_ONES) && (COUNT == '0);
    assign down_wrap   = (prev_count == '0) && (COUNT == ALL_ONES);
    assign wrap_strobe = prev_valid && (up_wrap || down_wrap);

endmodule

// File: rtl/count_threshold_monitor.sv
// rtl/count_threshold_monitor.sv - hysteresis threshold, wrap tally and level interrupt
module count_threshold_monitor
    import count_threshold_monitor_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WRAP_W = DEF_WRAP_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WIDTH-1:0]  COUNT,
    input  logic [WIDTH-1:0]  THRESH_HI,
    input  logic [WIDTH-1:0]  THRESH_LO,
    input  logic              IRQ_ACK,
    input  logic              CLR_WRAP,
    output logic              ABOVE,
    output logic              TC_PULSE,
    output logic [WRAP_W-1:0] WRAP_CNT,
    output logic              IRQ,
    output logic [1:0]        IRQ_CAUSE
);

    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    state_t     state_q;
    state_t     state_d;
    logic       wrap;
    logic       prev_valid;
    logic       thr_rise;
    logic [1:0] cause_set;

    count_threshold_monitor_wrap_detector #(
        .WIDTH(WIDTH)
    ) u_wrap_detector (
        .CLK        (CLK),
        .RESET      (RESET),
        .COUNT      (COUNT),
        .wrap_strobe(wrap),
        .prev_valid (prev_valid)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // The priming sample loads the state directly; afterwards only the current state's exit test applies.
    always_comb begin
        state_d = state_q;
        if (!prev_valid) begin
            state_d = (COUNT >= THRESH_HI) ? ST_HIGH : ST_LOW;
        end else begin
            case (state_q)
                ST_LOW:  if (COUNT >= THRESH_HI) state_d = ST_HIGH;
                ST_HIGH: if (COUNT <= THRESH_LO) state_d = ST_LOW;
                default: state_d = ST_LOW;
            endcase
        end
    end

    always_comb begin
        thr_rise              = prev_valid && (state_q == ST_LOW) && (state_d == ST_HIGH);
        cause_set             = 2'b00;
        cause_set[CAUSE_THR]  = thr_rise;
        cause_set[CAUSE_WRAP] = wrap;
        ABOVE                 = (state_q == ST_HIGH);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            TC_PULSE  <= 1'b0;
            WRAP_CNT  <= '0;
            IRQ       <= 1'b0;
            IRQ_CAUSE <= 2'b00;
        end else begin
            TC_PULSE <= wrap;

            if (CLR_WRAP) begin
                WRAP_CNT <= '0;
            end else if (wrap && (WRAP_CNT != WRAP_MAX)) begin
                WRAP_CNT <= WRAP_CNT + 1'b1;
            end

            // A new event beats a same-cycle acknowledge and replaces the old cause bits.
            if (cause_set != 2'b00) begin
                IRQ       <= 1'b1;
                IRQ_CAUSE <= IRQ_ACK ? cause_set : (IRQ_CAUSE | cause_set);
            end else if (IRQ_ACK) begin
                IRQ       <= 1'b0;
                IRQ_CAUSE <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_count_threshold_monitor.sv
// tb/tb_count_threshold_monitor.sv - directed and randomized checks against a behavioural model
module tb_count_threshold_monitor;

    logic       CLK;
    logic       RESET;
    logic [4:0] COUNT;
    logic [4:0] THRESH_HI;
    logic [4:0] THRESH_LO;
    logic       IRQ_ACK;
    logic       CLR_WRAP;
    logic       ABOVE;
    logic       TC_PULSE;
    logic [7:0] WRAP_CNT;
    logic       IRQ;
    logic [1:0] IRQ_CAUSE;

    int vectors;
    int miscompares;

    // behavioural model state
    bit         m_pv;
    int         m_prev;
    bit         m_above;
    bit         m_tc;
    int         m_wc;
    bit         m_irq;
    logic [1:0] m_cause;

    count_threshold_monitor dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .COUNT    (COUNT),
        .THRESH_HI(THRESH_HI),
        .THRESH_LO(THRESH_LO),
        .IRQ_ACK  (IRQ_ACK),
        .CLR_WRAP (CLR_WRAP),
        .ABOVE    (ABOVE),
        .TC_PULSE (TC_PULSE),
        .WRAP_CNT (WRAP_CNT),
        .IRQ      (IRQ),
        .IRQ_CAUSE(IRQ_CAUSE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        vectors++;
        chk("above", {31'd0, ABOVE}, {31'd0, m_above});
        chk("tc_pulse", {31'd0, TC_PULSE}, {31'd0, m_tc});
        chk("wrap_cnt", {24'd0, WRAP_CNT}, m_wc);
        chk("irq", {31'd0, IRQ}, {31'd0, m_irq});
        chk("irq_cause", {30'd0, IRQ_CAUSE}, {30'd0, m_cause});
    endtask

    task automatic m_reset();
        m_pv    = 0;
        m_prev  = 0;
        m_above = 0;
        m_tc    = 0;
        m_wc    = 0;
        m_irq   = 0;
        m_cause = 2'b00;
    endtask

    task automatic step(input int c, input int ack = 0, input int clr = 0);
        int         hi;
        int         lo;
        bit         wrapped;
        bit         rose;
        logic [1:0] nb;
        COUNT    = c[4:0];
        IRQ_ACK  = ack[0];
        CLR_WRAP = clr[0];
        @(posedge CLK);
        hi      = int'(THRESH_HI);
        lo      = int'(THRESH_LO);
        wrapped = m_pv && ((m_prev == 31 && c == 0) || (m_prev == 0 && c == 31));
        rose    = 0;
        if (!m_pv) m_above = (c >= hi);
        else if (!m_above && c >= hi) begin
            m_above = 1;
            rose    = 1;
        end else if (m_above && c <= lo) m_above = 0;
        if (clr != 0) m_wc = 0;
        else if (wrapped && m_wc < 255) m_wc++;
        nb = {wrapped, rose};
        if (nb != 2'b00) begin
            m_irq   = 1;
            m_cause = (ack != 0) ? nb : (m_cause | nb);
        end else if (ack != 0) begin
            m_irq   = 0;
            m_cause = 2'b00;
        end
        m_tc   = wrapped;
        m_pv   = 1;
        m_prev = c;
        #1;
        check_all();
    endtask

    // Called 1 time unit after a rising edge: reset lands between edges and releases before the next one.
    task automatic do_reset();
        #2;
        RESET = 1'b0;
        #1;
        m_reset();
        check_all();
        #2;
        RESET = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RESET       = 1'b0;
        COUNT       = 5'd31;
        THRESH_HI   = 5'd20;
        THRESH_LO   = 5'd10;
        IRQ_ACK     = 1'b0;
        CLR_WRAP    = 1'b0;
        m_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all();
        #4;
        RESET = 1'b1;

        // priming with all-ones
        step(31);
        chk("p1_above", {31'd0, ABOVE}, 32'd1);
        chk("p1_irq", {31'd0, IRQ}, 32'd0);

        // up-wrap then acknowledge
        step(30);
        step(31);
        step(0);
        chk("p2_tc", {31'd0, TC_PULSE}, 32'd1);
        chk("p2_wrap_cnt", {24'd0, WRAP_CNT}, 32'd1);
        chk("p2_cause", {30'd0, IRQ_CAUSE}, 32'd2);
        step(1, 1);
        chk("p2_ack_irq", {31'd0, IRQ}, 32'd0);

        // hysteresis
        step(18);
        step(21);
        chk("p3_rise1", {31'd0, ABOVE}, 32'd1);
        step(15);
        step(21);
        step(9);
        chk("p3_fall", {31'd0, ABOVE}, 32'd0);
        step(21);
        chk("p3_rise2", {30'd0, IRQ_CAUSE}, 32'd1);

        // pending threshold cause, then down-wrap with acknowledge
        step(5, 1);
        THRESH_HI = 5'd0;
        step(0);
        chk("p4_pending", {30'd0, IRQ_CAUSE}, 32'd1);
        step(31, 1);
        chk("p4_irq", {31'd0, IRQ}, 32'd1);
        chk("p4_cause", {30'd0, IRQ_CAUSE}, 32'd2);

        // saturation and clear-with-wrap
        THRESH_HI = 5'd20;
        step(31, 1);
        for (int i = 0; i < 260; i++) begin
            step(0);
            step(31);
        end
        chk("p5_sat", {24'd0, WRAP_CNT}, 32'd255);
        step(0, 0, 1);
        chk("p5_clr", {24'd0, WRAP_CNT}, 32'd0);
        chk("p5_tc", {31'd0, TC_PULSE}, 32'd1);

        // async reset mid-operation
        for (int i = 0; i < 7; i++) step((i % 2 == 0) ? 31 : 0);
        chk("p6_pre_cnt", {24'd0, WRAP_CNT}, 32'd7);
        chk("p6_pre_irq", {31'd0, IRQ}, 32'd1);
        do_reset();
        step(0);
        chk("p6_tc", {31'd0, TC_PULSE}, 32'd0);
        chk("p6_irq", {31'd0, IRQ}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            int c;
            r = $urandom_range(0, 9);
            c = (r < 2) ? 0 : (r < 4) ? 31 : $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) begin
                THRESH_HI = 5'($urandom_range(0, 31));
                THRESH_LO = 5'($urandom_range(0, 31));
            end
            step(c, ($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 15) == 0) ? 1 : 0);
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_threshold_monitor.md
Name: count_threshold_monitor

Overview:
Downstream consumer of the 5-bit up/down synchronous counter's Q output. Samples the count every clock and tracks threshold crossings with hysteresis. Detects wrap-around in either direction, keeps a saturating wrap tally, and raises a level interrupt that is held until acknowledged. Sits between the counter and the control/status logic that services interrupts.

Parameters:
WIDTH, 5, counter width; must match the counter's Q width.
WRAP_W, 8, width of the wrap tally.

Ports:
CLK  input  1  system clock; all logic on posedge.
RESET  input  1  asynchronous, active-low reset.
COUNT  input  WIDTH  counter Q output.
THRESH_HI  input  WIDTH  rising threshold (unsigned).
THRESH_LO  input  WIDTH  falling threshold (unsigned).
IRQ_ACK  input  1  interrupt acknowledge; sampled on posedge.
CLR_WRAP  input  1  synchronous clear of WRAP_CNT.
ABOVE  output  1  hysteresis state: 1 = HIGH, 0 = LOW.
TC_PULSE  output  1  one-cycle pulse on a detected wrap.
WRAP_CNT  output  WRAP_W  saturating count of wraps.
IRQ  output  1  interrupt request, level.
IRQ_CAUSE  output  2  sticky cause: bit0 = threshold rise, bit1 = wrap.

Behaviour:
- Reset: one clock (CLK); reset is asynchronous and active-low (RESET). RESET=0 immediately forces the following state:
  - ABOVE=0, TC_PULSE=0, WRAP_CNT=0, IRQ=0, IRQ_CAUSE=0.
  - Internal prev_count=0 and prev_valid=0.
- Reset mid-operation: aborts everything with no pending state retained.
- Every output is registered. Response appears 1 cycle after the COUNT sample that caused it.
- Priming sample: prev_valid is set on the first posedge after reset release. On that cycle:
  - ABOVE initialises to (COUNT >= THRESH_HI).
  - No wrap, TC_PULSE, or IRQ event is generated. This covers the counter resetting to all-ones in down mode.
- Every edge after priming: prev_count <= COUNT.
- Wrap detection (direction-agnostic, no UP_DOWN input):
  - up-wrap = (prev_count == all-ones) && (COUNT == 0).
  - down-wrap = (prev_count == 0) && (COUNT == all-ones).
  - An unchanged COUNT (held) is never a wrap.
- On a wrap:
  - TC_PULSE=1 for exactly one cycle.
  - WRAP_CNT increments, saturating at 2^WRAP_W-1 with no rollover.
  - CLR_WRAP has priority over a same-cycle increment; the result is 0.
- Hysteresis FSM, two states:
  - LOW -> HIGH when COUNT >= THRESH_HI.
  - HIGH -> LOW when COUNT <= THRESH_LO.
  - Only the condition for the current state is evaluated. Misconfiguration (THRESH_LO >= THRESH_HI) therefore cannot oscillate within a cycle, only toggle once per sample.
- Interrupt events are LOW->HIGH transitions (cause bit0) and wraps (cause bit1). HIGH->LOW raises no event.
- IRQ handshake:
  - Any event sets IRQ=1 and ORs its bit into IRQ_CAUSE.
  - IRQ_ACK=1 clears IRQ and IRQ_CAUSE.
  - Same-cycle event and ACK: the event wins. IRQ stays 1 and IRQ_CAUSE holds only the newly set bits.
  - ACK while IRQ=0 has no effect.
- Arithmetic: all compares are unsigned WIDTH-bit. WRAP_CNT increment is WRAP_W-bit with a saturation check before the add.

Decomposition:
- Shared package holds:
  - State constants ST_LOW=1'b0 and ST_HIGH=1'b1.
  - Cause bit indices CAUSE_THR=0 and CAUSE_WRAP=1.
  - Default WIDTH=5 and WRAP_W=8.
- One natural sub-module, wrap_detector. It contains prev_count, prev_valid, and the up/down wrap compares, and outputs a single-cycle wrap strobe plus prev_valid.
- FSM, tally, and IRQ logic stay in the top module.

Test Plan:
1. Priming: COUNT=5'h1F at reset release, THRESH_HI=20 -> ABOVE=1 after the first edge, IRQ=0, TC_PULSE=0.
2. Up-wrap: COUNT 30,31,0,1 -> TC_PULSE high exactly 1 cycle after 0 is sampled, WRAP_CNT=1, IRQ=1, IRQ_CAUSE=2'b10. Then IRQ_ACK=1 for 1 cycle -> IRQ=0, IRQ_CAUSE=0.
3. Hysteresis: THRESH_HI=20, THRESH_LO=10, COUNT 18,21,15,21,9,21:
   - ABOVE goes 1 at 21 and stays 1 through 15 and 21.
   - ABOVE goes 0 at 9 and 1 again at 21.
   - IRQ_CAUSE bit0 set on both rises.
4. Simultaneous ACK and wrap: IRQ pending with cause=01, down-wrap 0->31 in the same cycle as IRQ_ACK=1 -> IRQ stays 1, IRQ_CAUSE=2'b10.
5. Saturation and clear: 260 consecutive up-wraps -> WRAP_CNT holds 255. CLR_WRAP asserted together with a wrap -> WRAP_CNT=0, TC_PULSE still 1.
6. Async reset mid-operation: RESET=0 between edges while IRQ=1 and WRAP_CNT=7 -> all outputs 0 immediately. The next sample after release produces no event even if COUNT=0 follows a prior 31.
